// File: rtl/error_combiner_pipe.sv
// Pipelined weighted phase-error combiner for the ADPLL loop filter path.
// Per-channel signed multiply, sum, arithmetic normalise, saturate; 3-cycle latency.
module error_combiner_pipe #(
    parameter int NUM_CHANNELS = 4,
    parameter int ERROR_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int NORM_SHIFT   = 2,
    parameter int SATCNT_WIDTH = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 valid_i,
    input  logic [NUM_CHANNELS*ERROR_WIDTH-1:0]  error_i,
    input  logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0] weight_i,
    input  logic [NUM_CHANNELS-1:0]              chan_en_i,
    output logic                                 valid_o,
    output logic [ERROR_WIDTH-1:0]               error_comb_o,
    output logic                                 sat_o,
    output logic [SATCNT_WIDTH-1:0]              sat_count_o
);

    localparam int NC = NUM_CHANNELS;
    localparam int EW = ERROR_WIDTH;
    localparam int WW = WEIGHT_WIDTH;
    localparam int PW = EW + WW;
    localparam int SW = PW + $clog2(NC);

    localparam logic signed [SW-1:0] MAXV =
        {{(SW-EW+1){1'b0}}, {(EW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV =
        {{(SW-EW+1){1'b1}}, {(EW-1){1'b0}}};

    logic signed [PW-1:0] w_prod [NC];
    logic signed [PW-1:0] r_prod [NC];
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] r_sum;
    logic signed [SW-1:0] r_norm;
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_v3;
    logic                 w_hi;
    logic                 w_lo;
    logic [EW-1:0]        w_res;

    always_comb begin
        for (int k = 0; k < NC; k++) begin
            w_prod[k] = '0;
            if (chan_en_i[k]) begin
                w_prod[k] = PW'($signed(error_i[k*EW +: EW]))
                          * PW'($signed(weight_i[k*WW +: WW]));
            end
        end
    end

    // Sign-extend each product before summing so the sum cannot overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NC; k++) begin
            w_sum = w_sum + SW'(r_prod[k]);
        end
    end

    always_comb begin
        w_hi  = (r_norm > MAXV);
        w_lo  = (r_norm < MINV);
        w_res = r_norm[EW-1:0];
        if (w_hi) begin
            w_res = MAXV[EW-1:0];
        end else if (w_lo) begin
            w_res = MINV[EW-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_v3         <= 1'b0;
            valid_o      <= 1'b0;
            r_sum        <= '0;
            r_norm       <= '0;
            error_comb_o <= '0;
            sat_o        <= 1'b0;
            sat_count_o  <= '0;
            for (int k = 0; k < NC; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            r_v1    <= valid_i;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            valid_o <= r_v3;
            if (valid_i) begin
                for (int k = 0; k < NC; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end
            if (r_v1) begin
                r_sum <= w_sum;
            end
            if (r_v2) begin
                r_norm <= r_sum >>> NORM_SHIFT;
            end
            if (r_v3) begin
                error_comb_o <= w_res;
                sat_o        <= w_hi | w_lo;
                if ((w_hi | w_lo) && (sat_count_o != '1)) begin
                    sat_count_o <= sat_count_o + SATCNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_error_combiner_pipe.sv
// Bench for error_combiner_pipe: table vectors, corner sequences, random
// stimulus against a queue-based arithmetic reference model.
module tb_error_combiner_pipe;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              valid_i;
    logic [3:0][7:0]   error_i;
    logic [3:0][3:0]   weight_i;
    logic [3:0]        chan_en_i;
    logic              valid_o;
    logic [7:0]        error_comb_o;
    logic              sat_o;
    logic [15:0]       sat_count_o;

    logic              v2_i;
    logic [7:0][7:0]   e2_i;
    logic [7:0][3:0]   w2_i;
    logic [7:0]        en2_i;
    logic              v2_o;
    logic [7:0]        err2_o;
    logic              sat2_o;
    logic [1:0]        cnt2_o;

    error_combiner_pipe dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .valid_i      (valid_i),
        .error_i      (error_i),
        .weight_i     (weight_i),
        .chan_en_i    (chan_en_i),
        .valid_o      (valid_o),
        .error_comb_o (error_comb_o),
        .sat_o        (sat_o),
        .sat_count_o  (sat_count_o)
    );

    error_combiner_pipe #(
        .NUM_CHANNELS (8),
        .NORM_SHIFT   (0),
        .SATCNT_WIDTH (2)
    ) dut2 (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .valid_i      (v2_i),
        .error_i      (e2_i),
        .weight_i     (w2_i),
        .chan_en_i    (en2_i),
        .valid_o      (v2_o),
        .error_comb_o (err2_o),
        .sat_o        (sat2_o),
        .sat_count_o  (cnt2_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0][7:0] e;
        logic [3:0][3:0] w;
        logic [3:0]      en;
        int              val;
        bit              sat;
        int              cnt;
    } vec_t;

    typedef struct {
        int due;
        int val;
        bit sat;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   edge_cnt = 0;
    int   mcnt = 0;
    bit   mon_on = 0;
    exp_t q[$];
    vec_t tbl[7];

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum, floor division by 2^NORM_SHIFT, clip.
    function automatic void ref_calc(input logic [3:0][7:0] e,
                                     input logic [3:0][3:0] w,
                                     input logic [3:0] en,
                                     output int val, output bit sat);
        int s;
        int d;
        int n;
        s = 0;
        d = 4;
        for (int k = 0; k < 4; k++) begin
            if (en[k]) s += int'($signed(e[k])) * int'($signed(w[k]));
        end
        n = (s >= 0) ? s / d : -((-s + d - 1) / d);
        sat = 1'b0;
        val = n;
        if (n > 127) begin
            val = 127;
            sat = 1'b1;
        end else if (n < -128) begin
            val = -128;
            sat = 1'b1;
        end
    endfunction

    function automatic vec_t mk(input logic [3:0][7:0] e,
                                input logic [3:0][3:0] w,
                                input logic [3:0] en,
                                input int val, input bit sat, input int cnt);
        vec_t v;
        v.e = e; v.w = w; v.en = en;
        v.val = val; v.sat = sat; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic [3:0][7:0] e,
                         input logic [3:0][3:0] w,
                         input logic [3:0] en);
        exp_t x;
        valid_i   = 1'b1;
        error_i   = e;
        weight_i  = w;
        chan_en_i = en;
        @(posedge clk_i);
        #1;
        ref_calc(e, w, en, x.val, x.sat);
        x.due = edge_cnt + 3;
        q.push_back(x);
        valid_i   = 1'b0;
        error_i   = $urandom;
        weight_i  = $urandom;
        chan_en_i = 4'($urandom);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (mon_on) begin
            if (q.size() > 0 && q[0].due == edge_cnt) begin
                chk("mon_valid", valid_o, 1);
                chk("mon_value", $signed(error_comb_o), q[0].val);
                chk("mon_sat", sat_o, q[0].sat);
                if (q[0].sat && mcnt < 65535) mcnt++;
                chk("mon_count", sat_count_o, mcnt);
                void'(q.pop_front());
            end else begin
                chk("mon_idle_valid", valid_o, 0);
            end
        end
    end

    initial begin
        reset_i   = 1'b1;
        valid_i   = 1'b0;
        error_i   = '0;
        weight_i  = '0;
        chan_en_i = '0;
        v2_i      = 1'b0;
        e2_i      = {8{8'h80}};
        w2_i      = {8{4'h8}};
        en2_i     = 8'hFF;

        tbl[0] = mk({4{8'h80}}, {4{4'h1}}, 4'hF, -128, 0, 0);
        tbl[1] = mk({4{8'h7F}}, {4{4'h7}}, 4'hF, 127, 1, 1);
        tbl[2] = mk({4{8'h80}}, {4{4'h8}}, 4'hF, 127, 1, 2);
        tbl[3] = mk({8'd50, 8'd50, 8'd50, 8'hFF},
                    {4'd3, 4'd3, 4'd3, 4'd1}, 4'b0001, -1, 0, 2);
        tbl[4] = mk({8'd50, 8'd50, 8'd50, 8'hFF},
                    {4'd3, 4'd3, 4'd3, 4'd1}, 4'b0000, 0, 0, 2);
        tbl[5] = mk({4{8'h80}}, {4{4'h7}}, 4'hF, -128, 1, 3);
        tbl[6] = mk({8'd9, 8'd9, 8'd9, 8'd5},
                    {4'd2, 4'd2, 4'd2, 4'd1}, 4'b0001, 1, 0, 3);

        #3;
        chk("rst_valid", valid_o, 0);
        chk("rst_value", error_comb_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_count", sat_count_o, 0);
        chk("rst2_count", cnt2_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        mon_on = 1;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].e, tbl[i].w, tbl[i].en);
            idle(3);
            chk($sformatf("tbl%0d_valid", i), valid_o, 1);
            chk($sformatf("tbl%0d_value", i), $signed(error_comb_o), tbl[i].val);
            chk($sformatf("tbl%0d_sat", i), sat_o, tbl[i].sat);
            chk($sformatf("tbl%0d_count", i), sat_count_o, tbl[i].cnt);
            idle(1);
            chk($sformatf("tbl%0d_pulse", i), valid_o, 0);
            chk($sformatf("tbl%0d_hold", i), $signed(error_comb_o), tbl[i].val);
        end

        for (int i = 0; i < 8; i++) begin
            logic [7:0] e0;
            e0 = 8'(4 * i);
            drive({8'd3, 8'd3, 8'd3, e0}, {4'd1, 4'd1, 4'd1, 4'd1}, 4'b0001);
        end
        idle(5);
        chk("burst_hold", $signed(error_comb_o), 7);
        chk("burst_quiet", valid_o, 0);

        drive({4{8'd100}}, {4{4'd1}}, 4'hF);
        drive({4{8'd100}}, {4{4'd1}}, 4'hF);
        #2;
        reset_i = 1'b1;
        #1;
        q.delete();
        mcnt = 0;
        chk("arst_valid", valid_o, 0);
        chk("arst_value", error_comb_o, 0);
        chk("arst_sat", sat_o, 0);
        chk("arst_count", sat_count_o, 0);
        #2;
        reset_i = 1'b0;
        drive({8'd0, 8'd0, 8'd0, 8'd40}, {4'd0, 4'd0, 4'd0, 4'd1}, 4'hF);
        idle(2);
        chk("post_rst_early", valid_o, 0);
        idle(1);
        chk("post_rst_valid", valid_o, 1);
        chk("post_rst_value", $signed(error_comb_o), 10);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                drive($urandom, $urandom, 4'($urandom));
            end else begin
                idle(1);
            end
        end
        idle(5);

        v2_i = 1'b1;
        @(posedge clk_i);
        #1;
        v2_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("w8_early", v2_o, 0);
        @(posedge clk_i);
        #1;
        chk("w8_valid", v2_o, 1);
        chk("w8_value", $signed(err2_o), 127);
        chk("w8_sat", sat2_o, 1);
        chk("w8_count1", cnt2_o, 1);
        v2_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        v2_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        chk("w8_count_stick", cnt2_o, 3);
        chk("w8_hold", $signed(err2_o), 127);

        mon_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/error_combiner_pipe.md
# error_combiner_pipe

Parametrised, pipelined successor to the four-input weighted error combiner. It forms the weighted sum of NUM_CHANNELS signed phase-error inputs, with per-channel enable. It normalises the sum by an arithmetic right shift and saturates the result to the error width. It sits between the phase detectors and the loop filter of the ADPLL and adds a valid handshake, fixed 3-cycle latency and saturation reporting.

## Interface
- NUM_CHANNELS, 4, number of error/weight channels (≥1)
- ERROR_WIDTH, 8, signed width of each error input and of the output
- WEIGHT_WIDTH, 4, signed width of each weight
- NORM_SHIFT, 2, arithmetic right shift applied to the sum (0..8)
- SATCNT_WIDTH, 16, width of the saturation event counter

- clk_i  input  1  clock, all state on rising edge
- reset_i  input  1  asynchronous, active-high reset
- valid_i  input  1  input sample strobe, one sample per cycle when high
- error_i  input  NUM_CHANNELS*ERROR_WIDTH  packed signed errors, channel k at bits [k*ERROR_WIDTH +: ERROR_WIDTH]
- weight_i  input  NUM_CHANNELS*WEIGHT_WIDTH  packed signed weights, same packing
- chan_en_i  input  NUM_CHANNELS  per-channel enable; a disabled channel contributes 0
- valid_o  output  1  result strobe
- error_comb_o  output  ERROR_WIDTH  signed combined error; holds its value between strobes
- sat_o  output  1  high with valid_o when the current result was clipped
- sat_count_o  output  SATCNT_WIDTH  count of clipped results, sticks at all-ones

## Operation
- Stage 1, registered when valid_i=1: p[k] = chan_en_i[k] ? error[k]*weight[k] : 0. The multiply is signed, width PW = ERROR_WIDTH+WEIGHT_WIDTH. error_i, weight_i and chan_en_i are sampled together.
- Stage 2: s = Σ p[k], sign-extended to SW = PW + clog2(NUM_CHANNELS), so overflow is impossible.
- Stage 3: n = s >>> NORM_SHIFT. This is an arithmetic shift that floors toward −∞. There is no rounding.
- Saturation: compare n against 2^(ERROR_WIDTH−1)−1 and −2^(ERROR_WIDTH−1).
  - If n is out of range, error_comb_o takes the bound and sat_o=1.
  - Otherwise error_comb_o = n[ERROR_WIDTH−1:0] and sat_o=0.
- sat_count_o increments by 1 on each output strobe with sat_o=1. It never wraps.
- Pipeline stages are loaded only when their incoming valid bit is 1. The valid bit itself advances every cycle.
- Cycles with valid_i=0 produce no output strobe. error_comb_o and sat_o keep their last strobed values.
- There is no backpressure. The downstream loop filter must accept every strobe.
- Reset, asserted at any time including mid-pipeline, acts immediately:
  - All valid bits and data registers, error_comb_o, sat_o and sat_count_o are cleared to 0.
  - In-flight samples are discarded and no strobe is emitted for them.
- After reset deasserts, the first valid_i sampled on a clock edge produces valid_o three edges later.

## Timing
- Reset values: valid_o=0, error_comb_o=0, sat_o=0, sat_count_o=0.
- Latency: valid_i high at edge N gives valid_o, error_comb_o and sat_o updated at edge N+3. All outputs are registered.
- Throughput: 1 sample/cycle. Back-to-back valid_i yields back-to-back valid_o in the same order.
- valid_o is a single-cycle pulse per sample.
- sat_count_o updates on the same edge as the corresponding sat_o.
- Inputs need only be stable around the clk_i edge where valid_i=1.

## Test plan
All tests use default parameters unless stated.
- All four errors −128, weights 1, enable 4'hF, single valid -> 3 cycles later: error_comb_o=−128, sat_o=0, sat_count_o=0.
- All errors 127, weights 7 (sum 3556, shifted 889) -> error_comb_o=127, sat_o=1, sat_count_o=1. Repeat with errors −128, weights −8 (sum 4096) -> 127, sat_count_o=2.
- Rounding and masking: e0=−1, w0=1, chan_en_i=4'b0001, others nonzero -> −1, not 0 (floor), sat_o=0. Then chan_en_i=0 -> 0.
- Throughput: 8 consecutive valid cycles with e0 = 4·i (i=0..7), w0=1, others disabled -> 8 consecutive valid_o with outputs 0..7 in order. error_comb_o holds 7 after the burst.
- Reset mid-pipeline: 2 valid samples, then reset_i pulsed asynchronously between clock edges -> outputs 0 immediately, no valid_o for the flushed samples. A new sample after reset appears exactly 3 edges later.
- NORM_SHIFT=0, NUM_CHANNELS=8 build: all errors −128, weights −8 -> 127, sat_o=1. Force SATCNT_WIDTH=2 and send 5 saturating samples -> sat_count_o sticks at 3.
